fht_stage_ctrl: RTL and testbench

Sequencer for one radix-2 Hartley butterfly (fht_but), performing a complete in-place N-point FHT over ping-pong data memory.
- Generates the x0/x1/x2 read addresses, the twiddle ROM address, the write addresses/enable and the bank select for every butterfly of every stage.
- Timing is aligned to the butterfly's skewed input timing and its fixed latency.
- Sits between the top-level FHT control (start/ready) and the memory, ROM and butterfly datapath. Input data is already bit-reversed by upstream logic.

---
 rtl/fht_stage_ctrl.sv | 178 +++++++++++++++++
 tb/tb_fht_stage_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fht_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 FHT over ping-pong memory.
// Optional `FHT_STAGE_CTRL_HOLD_EN adds iHOLD to stall butterfly issue in RUN.
module fht_stage_ctrl #(
   parameter  int A_BIT   = 4,
   parameter  int RD_LAT  = 1,
   parameter  int BUT_LAT = 2,
   localparam int SW      = (A_BIT > 1) ? $clog2(A_BIT) : 1
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iSTART,
`ifdef FHT_STAGE_CTRL_HOLD_EN
   input  logic             iHOLD,
`endif
   output logic             oBUSY,
   output logic             oRDY,
   output logic             oRD_EN,
   output logic [A_BIT-1:0] oRD_ADDR_1,
   output logic [A_BIT-1:0] oRD_ADDR_2,
   output logic [A_BIT-1:0] oRD_ADDR_0,
   output logic             oRD_EN_0,
   output logic [A_BIT-2:0] oROM_ADDR,
   output logic             oRD_BANK,
   output logic             oWR_EN,
   output logic [A_BIT-1:0] oWR_ADDR_0,
   output logic [A_BIT-1:0] oWR_ADDR_1,
   output logic             oWR_BANK,
   output logic [SW-1:0]    oSTAGE
);

   localparam int N   = 1 << A_BIT;
   localparam int NB  = N / 2;
   localparam int DLY = RD_LAT + BUT_LAT;
   localparam int JW  = A_BIT - 1;
   localparam int DW  = $clog2(DLY + 1);
   localparam logic [A_BIT-1:0] ONE = 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   stage_q, stage_d;
   logic [JW-1:0]   bfly_q, bfly_d;
   logic [DW-1:0]   drain_q, drain_d;
   logic            hold;
   logic            issue;
   logic            busy;

   logic [A_BIT-1:0] half_w, mask_w, j_w, k_w, x0_w, x1_w, x2_w;
   logic [JW-1:0]    k_j, rom_w;

   logic             rd_en0_q;
   logic [A_BIT-1:0] rd_addr0_q;
   logic [DLY-1:0]   wv_q;
   logic [A_BIT-1:0] wa0_q [DLY];
   logic [A_BIT-1:0] wa1_q [DLY];

`ifdef FHT_STAGE_CTRL_HOLD_EN
   assign hold = iHOLD;
`else
   assign hold = 1'b0;
`endif

   // Butterfly index j enumerates k fastest then g: x0 is j with a 0 inserted at bit s.
   always_comb begin
      half_w = ONE << stage_q;
      mask_w = half_w - ONE;
      j_w    = {1'b0, bfly_q};
      k_w    = j_w & mask_w;
      x0_w   = ((j_w & ~mask_w) << 1) | k_w;
      x1_w   = x0_w | half_w;
      x2_w   = (x0_w & ~mask_w) | half_w | ((~k_w + ONE) & mask_w);
      k_j    = k_w[JW-1:0];
      rom_w  = k_j << (SW'(A_BIT - 1) - stage_q);
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q <= IDLE;
         stage_q <= '0;
         bfly_q  <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         bfly_q  <= bfly_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      bfly_d  = bfly_q;
      drain_d = drain_q;
      issue   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (iSTART) begin
               state_d = RUN;
               stage_d = '0;
               bfly_d  = '0;
               drain_d = '0;
            end
         end
         RUN: begin
            if (!hold) begin
               issue = 1'b1;
               if (bfly_q == JW'(NB - 1)) begin
                  bfly_d  = '0;
                  drain_d = '0;
                  state_d = DRAIN;
               end else begin
                  bfly_d = bfly_q + 1'b1;
               end
            end
         end
         // Next stage may only read once the last write of this stage is presented.
         DRAIN: begin
            if (drain_q == DW'(DLY - 1)) begin
               if (stage_q == SW'(A_BIT - 1)) begin
                  state_d = DONE;
               end else begin
                  stage_d = stage_q + 1'b1;
                  state_d = RUN;
               end
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            stage_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // x0 trails x1/x2 by one cycle; write addresses ride a DLY-deep shift register.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         rd_en0_q   <= 1'b0;
         rd_addr0_q <= '0;
         wv_q       <= '0;
         for (int i = 0; i < DLY; i++) begin
            wa0_q[i] <= '0;
            wa1_q[i] <= '0;
         end
      end else begin
         rd_en0_q   <= issue;
         rd_addr0_q <= issue ? x0_w : '0;
         wv_q[0]    <= issue;
         wa0_q[0]   <= issue ? x0_w : '0;
         wa1_q[0]   <= issue ? x1_w : '0;
         for (int i = 1; i < DLY; i++) begin
            wv_q[i]  <= wv_q[i-1];
            wa0_q[i] <= wa0_q[i-1];
            wa1_q[i] <= wa1_q[i-1];
         end
      end
   end

   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign oBUSY      = busy;
   assign oRDY       = (state_q == DONE);
   assign oRD_EN     = issue;
   assign oRD_ADDR_1 = issue ? x1_w : '0;
   assign oRD_ADDR_2 = issue ? x2_w : '0;
   assign oROM_ADDR  = issue ? rom_w : '0;
   assign oRD_EN_0   = rd_en0_q;
   assign oRD_ADDR_0 = rd_addr0_q;
   assign oRD_BANK   = busy & stage_q[0];
   assign oWR_BANK   = busy & ~stage_q[0];
   assign oWR_EN     = wv_q[DLY-1];
   assign oWR_ADDR_0 = wa0_q[DLY-1];
   assign oWR_ADDR_1 = wa1_q[DLY-1];
   assign oSTAGE     = stage_q;

endmodule

// File: tb/tb_fht_stage_ctrl.sv
// Self-checking bench for fht_stage_ctrl: per-cycle timeline model built from
// the stage/group/k addressing rules, randomized start noise, hold and reset.
module tb_fht_stage_ctrl;

   localparam int A_BIT   = 4;
   localparam int RD_LAT  = 1;
   localparam int BUT_LAT = 2;
   localparam int S       = A_BIT;
   localparam int N       = 1 << A_BIT;
   localparam int LAT     = RD_LAT + BUT_LAT;
   localparam int MAXC    = 200;

   logic       iCLK = 1'b0;
   logic       iRESET = 1'b0;
   logic       iSTART = 1'b0;
`ifdef FHT_STAGE_CTRL_HOLD_EN
   logic       iHOLD = 1'b0;
`endif
   logic       oBUSY, oRDY, oRD_EN, oRD_EN_0, oRD_BANK, oWR_EN, oWR_BANK;
   logic [3:0] oRD_ADDR_1, oRD_ADDR_2, oRD_ADDR_0, oWR_ADDR_0, oWR_ADDR_1;
   logic [2:0] oROM_ADDR;
   logic [1:0] oSTAGE;

   fht_stage_ctrl #(.A_BIT(A_BIT), .RD_LAT(RD_LAT), .BUT_LAT(BUT_LAT)) dut (
      .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
`ifdef FHT_STAGE_CTRL_HOLD_EN
      .iHOLD(iHOLD),
`endif
      .oBUSY(oBUSY), .oRDY(oRDY), .oRD_EN(oRD_EN),
      .oRD_ADDR_1(oRD_ADDR_1), .oRD_ADDR_2(oRD_ADDR_2), .oRD_ADDR_0(oRD_ADDR_0),
      .oRD_EN_0(oRD_EN_0), .oROM_ADDR(oROM_ADDR), .oRD_BANK(oRD_BANK),
      .oWR_EN(oWR_EN), .oWR_ADDR_0(oWR_ADDR_0), .oWR_ADDR_1(oWR_ADDR_1),
      .oWR_BANK(oWR_BANK), .oSTAGE(oSTAGE)
   );

   always #5 iCLK = ~iCLK;

   int checks = 0;
   int errors = 0;
   int cur_c  = 0;

   bit hold_m [MAXC];
   int e_rd_en[MAXC], e_a1[MAXC], e_a2[MAXC], e_rom[MAXC];
   int e_en0[MAXC], e_a0[MAXC], e_wen[MAXC], e_w0[MAXC], e_w1[MAXC];
   int e_busy[MAXC], e_rdy[MAXC], e_stage[MAXC];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: got %0d expected %0d", tag, cur_c, obs, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {oBUSY, oRDY, oRD_EN, oRD_ADDR_1, oRD_ADDR_2, oRD_ADDR_0, oRD_EN_0,
              oROM_ADDR, oRD_BANK, oWR_EN, oWR_ADDR_0, oWR_ADDR_1, oWR_BANK, oSTAGE};
   endfunction

   // Timeline indexed by cycles after the start edge (cycle 1 = first issue slot).
   task automatic build_model(output int rdy_c);
      int c;
      for (int i = 0; i < MAXC; i++) begin
         e_rd_en[i] = 0; e_a1[i] = 0; e_a2[i] = 0; e_rom[i] = 0;
         e_en0[i] = 0; e_a0[i] = 0; e_wen[i] = 0; e_w0[i] = 0; e_w1[i] = 0;
         e_busy[i] = 0; e_rdy[i] = 0; e_stage[i] = 0;
      end
      c = 1;
      for (int s = 0; s < S; s++) begin
         int h;
         int first;
         h = 1 << s;
         first = c;
         for (int g = 0; g < N; g += 2 * h) begin
            for (int k = 0; k < h; k++) begin
               while (hold_m[c]) c++;
               e_rd_en[c] = 1;
               e_a1[c]  = g + h + k;
               e_a2[c]  = g + h + ((h - k) % h);
               e_rom[c] = k << (S - 1 - s);
               e_en0[c+1] = 1;
               e_a0[c+1]  = g + k;
               e_wen[c+LAT] = 1;
               e_w0[c+LAT]  = g + k;
               e_w1[c+LAT]  = g + h + k;
               c++;
            end
         end
         for (int x = first; x < c + LAT; x++) begin
            e_busy[x]  = 1;
            e_stage[x] = s;
         end
         c = c + LAT;
      end
      e_rdy[c] = 1;
      rdy_c = c;
   endtask

   task automatic check_cycle(input int c);
      chk("busy", oBUSY, e_busy[c]);
      chk("rdy", oRDY, e_rdy[c]);
      chk("rd_en", oRD_EN, e_rd_en[c]);
      chk("rd_en_0", oRD_EN_0, e_en0[c]);
      chk("wr_en", oWR_EN, e_wen[c]);
      if (e_busy[c] != 0) begin
         chk("stage", oSTAGE, e_stage[c]);
         chk("rd_bank", oRD_BANK, e_stage[c] & 1);
         chk("wr_bank", oWR_BANK, 1 - (e_stage[c] & 1));
      end
      if (e_rd_en[c] != 0) begin
         chk("rd_addr_1", oRD_ADDR_1, e_a1[c]);
         chk("rd_addr_2", oRD_ADDR_2, e_a2[c]);
         chk("rom_addr", oROM_ADDR, e_rom[c]);
      end
      if (e_en0[c] != 0) chk("rd_addr_0", oRD_ADDR_0, e_a0[c]);
      if (e_wen[c] != 0) begin
         chk("wr_addr_0", oWR_ADDR_0, e_w0[c]);
         chk("wr_addr_1", oWR_ADDR_1, e_w1[c]);
      end
   endtask

   task automatic set_hold(input bit v);
`ifdef FHT_STAGE_CTRL_HOLD_EN
      iHOLD = v;
`else
      if (v) $display("hold request ignored: feature not built");
`endif
   endtask

   task automatic clear_hold();
      for (int i = 0; i < MAXC; i++) hold_m[i] = 1'b0;
   endtask

   task automatic run_trial(input int tid, input int spur_pct, input bit done_spur,
                            input int abort_at, output int rdy_at);
      int rc;
      int wcnt;
      int rcnt;
      wcnt = 0;
      rcnt = 0;
      rdy_at = -1;
      build_model(rc);
      @(posedge iCLK); #1;
      iSTART = 1'b1;
      for (int c = 1; c <= rc; c++) begin
         @(posedge iCLK); #1;
         iSTART = (c == rc) ? done_spur : ($urandom_range(99) < spur_pct);
         set_hold(hold_m[c]);
         @(negedge iCLK);
         cur_c = c;
         check_cycle(c);
         wcnt += int'(oWR_EN);
         rcnt += int'(oRDY);
         if (oRDY && rdy_at < 0) rdy_at = c;
         if (c == abort_at) begin
            #1 iRESET = 1'b0;
            #1;
            chk("reset_async_zero", all_outs(), 32'd0);
            @(posedge iCLK); #1;
            iRESET = 1'b1;
            iSTART = 1'b0;
            set_hold(1'b0);
            for (int i = 0; i < 60; i++) begin
               @(negedge iCLK);
               cur_c = c + 1 + i;
               chk("abort_no_wr", oWR_EN, 1'b0);
               chk("abort_no_rdy", oRDY, 1'b0);
               chk("abort_idle", oBUSY, 1'b0);
            end
            $display("trial %0d: aborted by reset at cycle %0d", tid, c);
            return;
         end
      end
      @(posedge iCLK); #1;
      iSTART = 1'b0;
      set_hold(1'b0);
      @(negedge iCLK);
      cur_c = rc + 1;
      chk("post_idle_busy", oBUSY, 1'b0);
      chk("post_idle_rd_en", oRD_EN, 1'b0);
      chk("post_idle_rdy", oRDY, 1'b0);
      chk("wr_count", wcnt, (N / 2) * S);
      chk("rdy_count", rcnt, 1);
      chk("rdy_cycle", rdy_at, rc);
      $display("trial %0d: oRDY at cycle %0d, %0d writes", tid, rdy_at, wcnt);
   endtask

   initial begin
      int r;
      clear_hold();
      iRESET = 1'b0;
      repeat (3) @(negedge iCLK);
      chk("reset_outputs_zero", all_outs(), 32'd0);
      @(posedge iCLK); #1;
      iRESET = 1'b1;
      repeat (2) @(posedge iCLK);

      run_trial(1, 0, 1'b0, 0, r);
      chk("t1_rdy_at_45", r, 45);
      repeat ($urandom_range(3)) @(posedge iCLK);

      run_trial(2, 20, 1'b1, 0, r);
      chk("t2_rdy_at_45", r, 45);
      repeat ($urandom_range(3)) @(posedge iCLK);

      run_trial(3, 10, 1'b0, $urandom_range(33, 23), r);

      run_trial(4, 0, 1'b1, 0, r);
      chk("t4_rdy_at_45", r, 45);

`ifdef FHT_STAGE_CTRL_HOLD_EN
      clear_hold();
      for (int i = 3; i <= 7; i++) hold_m[i] = 1'b1;
      run_trial(5, 0, 1'b0, 0, r);
      chk("hold5_rdy_at_50", r, 50);
      for (int t = 6; t <= 7; t++) begin
         clear_hold();
         for (int i = 1; i <= 40; i++) hold_m[i] = ($urandom_range(3) == 0);
         run_trial(t, 15, 1'b1, 0, r);
      end
      clear_hold();
`endif

      run_trial(8, 25, 1'b1, 0, r);
      chk("t8_rdy_at_45", r, 45);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
